mem_port_arbiter: RTL and testbench

Shares one single-ported unified memory between the instruction-fetch unit and the MEM stage of the 5-stage pipeline. It serialises requests, tracks fixed memory latency with a counter, and returns read data and a one-cycle ready pulse to the winner. It also produces per-requester stall signals consumed by the pipeline hazard logic. It sits between the IFU/MEM stage and the shared memory model, replacing their separate IMEM/DMEM instances.

---
 rtl/pipeline_pkg.sv | 23 ++
 rtl/mem_lat_counter.sv | 26 ++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types and constants for the memory port arbiter
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    typedef enum logic {
        IF,
        DM
    } owner_t;

    localparam logic [31:0] TRAP_HALT = 32'h4400_0300;

    // On a tie the requester that did not win last time is served.
    function automatic logic pick_dm(input logic if_pend, input logic dm_pend, input owner_t last);
        return dm_pend && (!if_pend || (last == IF));
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// rtl/mem_lat_counter.sv - loadable down-counter flagging the cycle memory read data is valid
module mem_lat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clock_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             hit_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign hit_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between instruction fetch and the MEM stage
module mem_port_arbiter
    import pipeline_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [3:0]        dm_be,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int CNT_W = 4;

    arb_state_t        state_q;
    owner_t            own_q;
    owner_t            last_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [3:0]        mem_be_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              if_ready_q;
    logic              dm_ready_q;

    logic if_pend;
    logic dm_pend;
    logic grant;
    logic win_dm;
    logic cnt_hit;

    // The owner that is completing in DONE cannot win again straight away.
    always_comb begin
        if_pend = 1'b0;
        dm_pend = 1'b0;
        if (state_q == IDLE) begin
            if_pend = if_req;
            dm_pend = dm_req;
        end else if (state_q == DONE) begin
            if_pend = if_req && (own_q != IF);
            dm_pend = dm_req && (own_q != DM);
        end
        grant  = if_pend || dm_pend;
        win_dm = pick_dm(if_pend, dm_pend, last_q);
    end

    mem_lat_counter #(
        .CNT_W(CNT_W)
    ) u_lat_cnt (
        .clock_i    (clock),
        .rst_n_i    (reset),
        .load_i     (grant),
        .load_val_i (CNT_W'(MEM_LAT)),
        .hit_o      (cnt_hit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            own_q       <= IF;
            last_q      <= IF;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'h0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
        end else begin
            mem_en_q   <= 1'b0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (grant) begin
                        state_q  <= ISSUE;
                        mem_en_q <= 1'b1;
                        own_q    <= win_dm ? DM : IF;
                        last_q   <= win_dm ? DM : IF;
                        if (win_dm) begin
                            mem_we_q    <= dm_we;
                            mem_addr_q  <= dm_addr;
                            mem_wdata_q <= dm_wdata;
                            mem_be_q    <= dm_be;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= if_addr & ~ADDR_W'(3);
                            mem_wdata_q <= '0;
                            mem_be_q    <= 4'hF;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE, WAIT: begin
                    // With MEM_LAT of 1 the hit already arrives in ISSUE.
                    if (cnt_hit) begin
                        state_q <= DONE;
                        if (own_q == IF) begin
                            if_rdata_q <= mem_rdata;
                            if_ready_q <= 1'b1;
                        end else begin
                            if (!mem_we_q) begin
                                dm_rdata_q <= mem_rdata;
                            end
                            dm_ready_q <= 1'b1;
                        end
                    end else begin
                        state_q <= WAIT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign stall_if  = if_req & ~if_ready_q;
    assign stall_mem = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a synchronous memory model
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [3:0]  dm_be = 4'hF;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;
    logic        stall_if;
    logic        stall_mem;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          cyc;
    } cmd_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    cmd_t        cmd_exp[$];
    rsp_t        if_exp[$];
    rsp_t        dm_exp[$];
    cmd_t        mon_c;
    rsp_t        mon_r;
    logic [31:0] mem [0:4095];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .MEM_LAT (LAT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_be     (dm_be),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Read data appears the cycle after mem_en, matching MEM_LAT of 2; be bit 0 is the MSB byte.
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem[mem_addr[13:2]][31-8*b -: 8] <= mem_wdata[31-8*b -: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr[13:2]];
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic exp_cmd(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd, input int c);
        cmd_t e;
        e.addr = a; e.we = we; e.be = be; e.wdata = wd; e.cyc = c;
        cmd_exp.push_back(e);
    endtask

    task automatic exp_rsp(input bit is_dm, input logic [31:0] d, input int c);
        rsp_t e;
        e.data = d; e.cyc = c;
        if (is_dm) dm_exp.push_back(e);
        else if_exp.push_back(e);
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (mem_en) begin
                if (cmd_exp.size() == 0) begin
                    check("mem_en_unexpected", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    mon_c = cmd_exp.pop_front();
                    check("mem_cmd", 64'({mem_addr, mem_we, mem_be}), 64'({mon_c.addr, mon_c.we, mon_c.be}));
                    if (mon_c.we) check("mem_wdata", 64'(mem_wdata), 64'(mon_c.wdata));
                    check("mem_en_cycle", 64'(cyc), 64'(mon_c.cyc));
                end
            end
            if (if_ready) begin
                if (if_exp.size() == 0) begin
                    check("if_ready_unexpected", 64'(if_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    mon_r = if_exp.pop_front();
                    check("if_rdata", 64'(if_rdata), 64'(mon_r.data));
                    check("if_ready_cycle", 64'(cyc), 64'(mon_r.cyc));
                end
            end
            if (dm_ready) begin
                if (dm_exp.size() == 0) begin
                    check("dm_ready_unexpected", 64'(dm_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    mon_r = dm_exp.pop_front();
                    check("dm_rdata", 64'(dm_rdata), 64'(mon_r.data));
                    check("dm_ready_cycle", 64'(cyc), 64'(mon_r.cyc));
                end
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rdata"}, {if_rdata, dm_rdata}, 64'd0);
        check({tag, "_ctrl"}, 64'({mem_en, mem_we, mem_addr, mem_be, if_ready, dm_ready, stall_if, stall_mem}), 64'd0);
        check({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1 reset = 1'b0;
        if_req = 1'b0;
        dm_req = 1'b0;
        #1 check_zero_outputs("reset");
        @(posedge clock);
        #1 reset = 1'b1;
    endtask

    // Holds the request across n_txn back-to-back transactions, stepping the address by 4.
    task automatic serve(input bit is_dm, input bit we, input logic [31:0] base, input logic [31:0] wd,
                         input logic [3:0] be, input int n_txn, output int stalls);
        bit got;
        stalls = 0;
        for (int t = 0; t < n_txn; t++) begin
            if (is_dm) begin
                dm_req = 1'b1; dm_we = we; dm_addr = base + 32'(4 * t); dm_wdata = wd; dm_be = be;
            end else begin
                if_req = 1'b1; if_addr = base + 32'(4 * t);
            end
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clock);
                if (is_dm ? stall_mem : stall_if) stalls++;
                if (is_dm ? dm_ready : if_ready) got = 1'b1;
            end
            if (!got) check(is_dm ? "dm_ready_timeout" : "if_ready_timeout", 64'd0, 64'd1);
            @(posedge clock);
            #1;
        end
        if (is_dm) dm_req = 1'b0;
        else if_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got %0d cycles want completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int st;
        int st2;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[12'h001] = 32'h2001_0005;
        mem[12'h002] = 32'h0000_0008;
        mem[12'h040] = 32'hDEAD_BEEF;
        mem[12'h800] = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            mem[12'h0C0 + 12'(i)] = 32'hA000_0000 + 32'(i);
            mem[12'h100 + 12'(i)] = 32'hB000_0000 + 32'(i);
        end

        repeat (2) @(posedge clock);
        #1 check_zero_outputs("por");
        reset = 1'b1;

        // Isolated fetch.
        @(posedge clock);
        #1 n = cyc;
        exp_cmd(32'h0000_0004, 1'b0, 4'hF, 32'h0, n + 1);
        exp_rsp(1'b0, 32'h2001_0005, n + 3);
        serve(1'b0, 1'b0, 32'h0000_0004, 32'h0, 4'h0, 1, st);
        check("stall_if_cycles", 64'(st), 64'd3);

        // Simultaneous requests right after reset: DM first, IF behind it.
        do_reset();
        n = cyc;
        exp_cmd(32'h0000_0100, 1'b0, 4'hF, 32'h0, n + 1);
        exp_cmd(32'h0000_0008, 1'b0, 4'hF, 32'h0, n + 4);
        exp_rsp(1'b1, 32'hDEAD_BEEF, n + 3);
        exp_rsp(1'b0, 32'h0000_0008, n + 6);
        fork
            serve(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 1, st);
            serve(1'b0, 1'b0, 32'h0000_0008, 32'h0, 4'h0, 1, st2);
        join

        // Partial store, dm_rdata must keep the previous load value, then read it back.
        n = cyc;
        exp_cmd(32'h0000_2000, 1'b1, 4'b0011, 32'hAABB_CCDD, n + 1);
        exp_rsp(1'b1, 32'hDEAD_BEEF, n + 3);
        serve(1'b1, 1'b1, 32'h0000_2000, 32'hAABB_CCDD, 4'b0011, 1, st);
        check("stall_mem_cycles", 64'(st), 64'd3);
        n = cyc;
        exp_cmd(32'h0000_2000, 1'b0, 4'hF, 32'h0, n + 1);
        exp_rsp(1'b1, 32'hAABB_5678, n + 3);
        serve(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF, 1, st);

        // Misaligned fetch is word-aligned.
        n = cyc;
        exp_cmd(32'h0000_0004, 1'b0, 4'hF, 32'h0, n + 1);
        exp_rsp(1'b0, 32'h2001_0005, n + 3);
        serve(1'b0, 1'b0, 32'h0000_0006, 32'h0, 4'h0, 1, st);

        // Both held for 10 transactions: strict alternation, DM first since IF won last.
        n = cyc;
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) begin
                exp_cmd(32'h0000_0300 + 32'(4 * (k / 2)), 1'b0, 4'hF, 32'h0, n + 1 + 3 * k);
                exp_rsp(1'b1, 32'hA000_0000 + 32'(k / 2), n + 3 + 3 * k);
            end else begin
                exp_cmd(32'h0000_0400 + 32'(4 * (k / 2)), 1'b0, 4'hF, 32'h0, n + 1 + 3 * k);
                exp_rsp(1'b0, 32'hB000_0000 + 32'(k / 2), n + 3 + 3 * k);
            end
        end
        fork
            serve(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 5, st);
            serve(1'b0, 1'b0, 32'h0000_0400, 32'h0, 4'h0, 5, st2);
        join

        // Reset in WAIT abandons the load; the next load completes normally.
        n = cyc;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0100; dm_be = 4'hF;
        exp_cmd(32'h0000_0100, 1'b0, 4'hF, 32'h0, n + 1);
        @(posedge clock);
        @(posedge clock);
        #3 reset = 1'b0;
        dm_req = 1'b0;
        #1 check_zero_outputs("async_reset");
        @(posedge clock);
        #1 reset = 1'b1;
        n = cyc;
        exp_cmd(32'h0000_2000, 1'b0, 4'hF, 32'h0, n + 1);
        exp_rsp(1'b1, 32'hAABB_5678, n + 3);
        serve(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF, 1, st);

        repeat (5) @(posedge clock);
        #1 check("queues_drained", 64'(cmd_exp.size() + if_exp.size() + dm_exp.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
